// File: rtl/lc3_mem_ctrl_pkg.sv
// Shared definitions for the LC-3 memory access unit: word width, FSM
// state encoding and a helper that sizes the wait counter.
package lc3_mem_ctrl_pkg;

    localparam int LC3_WORD_W = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    // Counter needs to hold MEM_LATENCY-1; never narrower than one bit.
    function automatic int cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/lc3_wait_counter.sv
// Loadable down-counter with a zero flag. Saturates at zero so it never
// wraps; any multi-cycle unit can use it to time a fixed-length wait.
module lc3_wait_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Count register, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Load has priority; decrement only while non-zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory access unit: owns MAR and MDR, runs one fixed-latency
// memory access per request and returns a one-cycle ready pulse.
module lc3_mem_ctrl
    import lc3_mem_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 3,
    parameter int ADDR_W      = LC3_WORD_W,
    parameter int DATA_W      = LC3_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_i,
    input  logic              ld_mar_i,
    input  logic              ld_mdr_i,
    input  logic              mio_en_i,
    input  logic              r_w_i,
    output logic              r_o,
    output logic [ADDR_W-1:0] mar_out_o,
    output logic [DATA_W-1:0] mdr_out_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int               CNT_W    = cnt_width(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              wr_q, wr_d;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;

    lc3_wait_counter #(
        .W (CNT_W)
    ) u_wait (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (CNT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // State, address, data and direction registers with async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            wr_q    <= wr_d;
        end
    end

    // Next-state logic and state-decoded outputs; loads only honoured in IDLE.
    always_comb begin
        state_d  = state_q;
        mar_d    = mar_q;
        mdr_d    = mdr_q;
        wr_d     = wr_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        r_o      = 1'b0;
        mem_en_o = 1'b0;
        mem_we_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ld_mar_i) begin
                    mar_d = ADDR_W'(bus_i);
                end
                if (mio_en_i) begin
                    wr_d     = r_w_i;
                    cnt_load = 1'b1;
                    state_d  = S_ACCESS;
                end else if (ld_mdr_i) begin
                    mdr_d = bus_i;
                end
            end
            S_ACCESS: begin
                mem_en_o = 1'b1;
                mem_we_o = wr_q;
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    if (!wr_q) begin
                        mdr_d = mem_rdata_i;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                r_o     = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mar_out_o   = mar_q;
    assign mdr_out_o   = mdr_q;
    assign mem_addr_o  = mar_q;
    assign mem_wdata_o = mdr_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Testbench for lc3_mem_ctrl: a transaction-level memory model predicts each
// access, a scoreboard queue holds the predictions and a negedge monitor
// compares them whenever the unit drives memory or signals ready.
module tb_lc3_mem_ctrl;

    localparam int LAT = 3;

    typedef struct {
        logic        isWrite;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] mdrAfter;
    } expT;

    logic        clk = 1'b0;
    logic        rstN;
    logic [15:0] bus;
    logic        ldMar, ldMdr, mioEn, rw;
    logic        rOut, memEn, memWe;
    logic [15:0] marOut, mdrOut, memAddr, memWdata, memRdata;

    logic        ldMar1, mioEn1;
    logic [15:0] bus1;
    logic        r1, memEn1, memWe1;
    logic [15:0] mar1, mdr1, memAddr1, memWdata1;

    int passCount  = 0;
    int totalCount = 0;
    int cycleNo    = 0;

    expT         scoreQ[$];
    logic [15:0] refMem[logic [15:0]];
    logic [15:0] devMem[logic [15:0]];
    logic [15:0] refMar, refMdr;

    int accCount = 0;
    logic prevEn = 1'b0;

    lc3_mem_ctrl #(.MEM_LATENCY(LAT), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rstN), .bus_i(bus), .ld_mar_i(ldMar), .ld_mdr_i(ldMdr),
        .mio_en_i(mioEn), .r_w_i(rw), .r_o(rOut), .mar_out_o(marOut),
        .mdr_out_o(mdrOut), .mem_en_o(memEn), .mem_we_o(memWe),
        .mem_addr_o(memAddr), .mem_wdata_o(memWdata), .mem_rdata_i(memRdata)
    );

    lc3_mem_ctrl #(.MEM_LATENCY(1), .ADDR_W(16), .DATA_W(16)) dut1 (
        .clk(clk), .rst_n(rstN), .bus_i(bus1), .ld_mar_i(ldMar1), .ld_mdr_i(1'b0),
        .mio_en_i(mioEn1), .r_w_i(1'b0), .r_o(r1), .mar_out_o(mar1),
        .mdr_out_o(mdr1), .mem_en_o(memEn1), .mem_we_o(memWe1),
        .mem_addr_o(memAddr1), .mem_wdata_o(memWdata1), .mem_rdata_i(16'h5A5A)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNo <= cycleNo + 1;

    function automatic logic [15:0] initWord(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5AC3;
    endfunction

    function automatic logic [15:0] refRead(input logic [15:0] a);
        return refMem.exists(a) ? refMem[a] : initWord(a);
    endfunction

    function automatic logic [15:0] devRead(input logic [15:0] a);
        return devMem.exists(a) ? devMem[a] : initWord(a);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic reportFail(input string name, input logic [31:0] act);
        totalCount++;
        $display("[TB] FAIL %s: got %h, expected no such event (t=%0t)", name, act, $time);
    endtask

    // Memory device: commits writes, returns stored data while reading.
    always @(posedge clk) begin
        if (rstN && memEn && memWe) devMem[memAddr] = memWdata;
    end

    always @(negedge clk) begin
        if (memEn && !memWe) memRdata = devRead(memAddr);
        else memRdata = 16'($urandom);
    end

    // Monitor: compare every memory cycle and ready pulse against the queue head.
    always @(negedge clk) begin
        expT e;
        if (!rstN) begin
            accCount = 0;
            prevEn   = 1'b0;
        end else begin
            if (memEn) begin
                if (scoreQ.size() == 0) begin
                    reportFail("unexpected access", 32'(memAddr));
                end else begin
                    checkOutput("mem addr", 32'(memAddr), 32'(scoreQ[0].addr));
                    checkOutput("mem we", 32'(memWe), 32'(scoreQ[0].isWrite));
                    if (scoreQ[0].isWrite)
                        checkOutput("mem wdata", 32'(memWdata), 32'(scoreQ[0].wdata));
                    accCount++;
                end
            end
            if (rOut) begin
                if (scoreQ.size() == 0) begin
                    reportFail("unexpected R", 32'(rOut));
                end else begin
                    e = scoreQ.pop_front();
                    checkOutput("access cycles", 32'(accCount), 32'(LAT));
                    checkOutput("R after access", 32'(prevEn), 32'(1));
                    checkOutput("mem en in DONE", 32'(memEn), 32'(0));
                    checkOutput("mdr after", 32'(mdrOut), 32'(e.mdrAfter));
                    checkOutput("mar after", 32'(marOut), 32'(e.addr));
                end
                accCount = 0;
            end
            prevEn = memEn;
        end
    end

    task automatic clearInputs();
        ldMar = 1'b0; ldMdr = 1'b0; mioEn = 1'b0; rw = 1'b0; bus = 16'h0000;
    endtask

    task automatic loadCycle(input bit toMar, input logic [15:0] val);
        @(posedge clk); #1;
        clearInputs();
        bus = val;
        if (toMar) begin ldMar = 1'b1; refMar = val; end
        else begin ldMdr = 1'b1; refMdr = val; end
    endtask

    // Predict the outcome of a request at transaction level and queue it.
    task automatic predict(input logic isWrite);
        expT e;
        e.isWrite = isWrite;
        e.addr    = refMar;
        e.wdata   = refMdr;
        if (isWrite) refMem[refMar] = refMdr;
        else refMdr = refRead(refMar);
        e.mdrAfter = refMdr;
        scoreQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic isWrite,
                                 input logic [15:0] wdata, input bit marSame, input bit garbage);
        bit seen = 0;
        if (!marSame) loadCycle(1'b1, addr);
        if (isWrite) loadCycle(1'b0, wdata);
        @(posedge clk); #1;
        clearInputs();
        mioEn = 1'b1;
        rw    = isWrite;
        ldMdr = 1'($urandom);
        bus   = 16'($urandom);
        if (marSame) begin ldMar = 1'b1; bus = addr; refMar = addr; end
        predict(isWrite);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rOut) begin seen = 1; break; end
            if (garbage) begin
                ldMar = 1'($urandom); ldMdr = 1'($urandom); rw = 1'($urandom);
                mioEn = 1'($urandom); bus = 16'($urandom);
            end else begin
                ldMar = 1'b0; ldMdr = 1'b0;
            end
        end
        clearInputs();
        if (!seen) begin
            reportFail("R timeout", 32'(addr));
            scoreQ.delete();
        end
    endtask

    initial begin
        logic [15:0] a;
        int t1, t2, nR;
        rstN = 1'b0;
        clearInputs();
        ldMar1 = 1'b0; mioEn1 = 1'b0; bus1 = 16'h0000;
        refMar = 16'h0000; refMdr = 16'h0000;
        refMem[16'h3000] = 16'hBEEF;
        devMem[16'h3000] = 16'hBEEF;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset R", 32'(rOut), 32'(0));
        checkOutput("reset mem en", 32'(memEn), 32'(0));
        checkOutput("reset mem we", 32'(memWe), 32'(0));
        checkOutput("reset mar", 32'(marOut), 32'(0));
        checkOutput("reset mdr", 32'(mdrOut), 32'(0));
        rstN = 1'b1;

        $display("[TB] directed read/write/freeze");
        applyStimulus(16'h3000, 1'b0, 16'h0000, 0, 0);
        checkOutput("read BEEF", 32'(mdrOut), 32'(16'hBEEF));
        applyStimulus(16'h0040, 1'b1, 16'h1234, 0, 0);
        checkOutput("write keeps mdr", 32'(mdrOut), 32'(16'h1234));
        applyStimulus(16'h0040, 1'b0, 16'h0000, 0, 1);
        applyStimulus(16'h2222, 1'b1, 16'h7777, 1, 1);

        $display("[TB] back-to-back");
        loadCycle(1'b1, 16'h0040);
        @(posedge clk); #1;
        clearInputs();
        mioEn = 1'b1;
        predict(1'b0);
        predict(1'b0);
        nR = 0; t1 = 0; t2 = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rOut) begin
                nR++;
                if (nR == 1) t1 = cycleNo; else t2 = cycleNo;
                if (nR == 2) break;
            end
        end
        clearInputs();
        if (nR < 2) begin
            reportFail("back-to-back R count", 32'(nR));
            scoreQ.delete();
        end else begin
            checkOutput("R spacing", 32'(t2 - t1), 32'(LAT + 2));
        end

        $display("[TB] randomized accesses");
        for (int n = 0; n < 40; n++) begin
            a = 16'h3000 + 16'($urandom_range(0, 7));
            applyStimulus(a, 1'($urandom), 16'($urandom), bit'($urandom), 1);
        end

        $display("[TB] reset mid-access");
        loadCycle(1'b1, 16'h1111);
        @(posedge clk); #1;
        clearInputs();
        mioEn = 1'b1;
        predict(1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("mid access en", 32'(memEn), 32'(1));
        rstN = 1'b0;
        mioEn = 1'b0;
        scoreQ.delete();
        refMar = 16'h0000; refMdr = 16'h0000;
        #1;
        checkOutput("abort R", 32'(rOut), 32'(0));
        checkOutput("abort mem en", 32'(memEn), 32'(0));
        checkOutput("abort mem we", 32'(memWe), 32'(0));
        checkOutput("abort mar", 32'(marOut), 32'(0));
        checkOutput("abort mdr", 32'(mdrOut), 32'(0));
        @(posedge clk); #1;
        rstN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checkOutput("no R after reset", 32'(rOut), 32'(0));
        end

        $display("[TB] latency 1 with dropped request");
        @(posedge clk); #1;
        bus1 = 16'h0123; ldMar1 = 1'b1;
        @(posedge clk); #1;
        ldMar1 = 1'b0; mioEn1 = 1'b1;
        @(posedge clk); #1;
        mioEn1 = 1'b0;
        checkOutput("lat1 en", 32'(memEn1), 32'(1));
        checkOutput("lat1 we", 32'(memWe1), 32'(0));
        checkOutput("lat1 addr", 32'(memAddr1), 32'(16'h0123));
        checkOutput("lat1 R early", 32'(r1), 32'(0));
        @(posedge clk); #1;
        checkOutput("lat1 R", 32'(r1), 32'(1));
        checkOutput("lat1 en off", 32'(memEn1), 32'(0));
        checkOutput("lat1 mdr", 32'(mdr1), 32'(16'h5A5A));
        checkOutput("lat1 wdata", 32'(memWdata1), 32'(16'h5A5A));
        checkOutput("lat1 mar", 32'(mar1), 32'(16'h0123));
        @(posedge clk); #1;
        checkOutput("lat1 R width", 32'(r1), 32'(0));

        repeat (4) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", 32'(scoreQ.size()), 32'(0));
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
